// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit handshake bundle between byte producers, the arbiter and uart_top.
// slave is the arbiter's view; master is the producer/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_byte;
    logic [NUM_REQ-1:0]   i_req_last;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic                 o_tx_dv;
    logic [7:0]           o_tx_byte;
    logic                 i_tx_active;
    logic                 i_tx_done;

    modport master (
        output i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
        input  o_req_ready, o_tx_dv, o_tx_byte
    );

    modport slave (
        input  i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
        output o_req_ready, o_tx_dv, o_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with packet locking (grant held until a byte flagged last) and a hung-transmitter watchdog.
module uart_tx_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int GAP_CYCLES     = 0,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_arbiter_if.slave bus,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_busy,
    output logic           o_timeout
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_KICK,
        S_WAIT,
        S_GAP
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] ready_q;
    logic               dv_q;
    logic [7:0]         byte_q;
    logic [IDW-1:0]     gid_q;
    logic               busy_q;
    logic               tmo_q;
    logic               lock_q;
    logic               last_q;
    logic [IDW-1:0]     ptr_q;
    logic [WDW-1:0]     wd_q;
    logic [7:0]         gap_q;

    logic               pick_vld_d;
    logic [IDW-1:0]     pick_id_d;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % NUM_REQ);
    endfunction

    // While locked only the owner (last granted id) may win; otherwise search ptr+1 onward,
    // so a lone requester equal to ptr is still found on the final step.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_id_d  = gid_q;
        if (lock_q) begin
            pick_vld_d = bus.i_req_valid[gid_q];
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (!pick_vld_d && bus.i_req_valid[wrap(int'(ptr_q) + i)]) begin
                    pick_vld_d = 1'b1;
                    pick_id_d  = wrap(int'(ptr_q) + i);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ready_q <= '0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            ptr_q   <= IDW'(NUM_REQ - 1);
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            dv_q  <= 1'b0;
            tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!bus.i_tx_active && pick_vld_d) begin
                        gid_q   <= pick_id_d;
                        ready_q <= NUM_REQ'(1) << pick_id_d;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    ready_q <= '0;
                    byte_q  <= bus.i_req_byte[8*gid_q +: 8];
                    last_q  <= bus.i_req_last[gid_q];
                    ptr_q   <= gid_q;
                    dv_q    <= 1'b1;
                    state_q <= S_KICK;
                end
                S_KICK: begin
                    // wd_q counts cycles since the o_tx_dv cycle, so the abort pulse
                    // lands exactly TIMEOUT_CYCLES after it
                    wd_q    <= WDW'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_tx_done) begin
                        lock_q <= !last_q;
                        if (GAP_CYCLES == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_q   <= 1'b1;
                        lock_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == 8'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready = ready_q;
    assign bus.o_tx_dv     = dv_q;
    assign bus.o_tx_byte   = byte_q;
    assign o_grant_id      = gid_q;
    assign o_busy          = busy_q;
    assign o_timeout       = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, latency, round-robin, lock, busy tx,
// watchdog abort and reset-under-lock, with the transmitter modelled by hand.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gid;
    logic       busy;
    logic       tmo;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .GAP_CYCLES(0),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave),
        .o_grant_id(gid),
        .o_busy(busy),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setreq(input int k, input logic v, input logic [7:0] b, input logic l);
        bus.i_req_valid[k]       = v;
        bus.i_req_byte[8*k +: 8] = b;
        bus.i_req_last[k]        = l;
    endtask

    // Wait for a grant to id, check the kick, then complete the frame with a tx_done pulse.
    task automatic serve(input int id, input logic [7:0] b, input bit more,
                         input logic [7:0] nb, input logic nl);
        int n = 0;
        while (bus.o_req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("grant_ready%0d", id), 32'(bus.o_req_ready), 32'(1 << id));
        chk($sformatf("grant_id%0d", id), 32'(gid), 32'(id));
        tick();
        if (more) setreq(id, 1'b1, nb, nl);
        else      setreq(id, 1'b0, 8'h00, 1'b0);
        chk("kick_dv", 32'(bus.o_tx_dv), 32'd1);
        chk("kick_byte", 32'(bus.o_tx_byte), 32'(b));
        chk("kick_ready", 32'(bus.o_req_ready), 32'd0);
        repeat (3) tick();
        chk("wait_dv", 32'(bus.o_tx_dv), 32'd0);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_byte  = '0;
        bus.i_req_last  = '0;
        bus.i_tx_active = 1'b0;
        bus.i_tx_done   = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_dv", 32'(bus.o_tx_dv), 32'd0);
        chk("rst_byte", 32'(bus.o_tx_byte), 32'd0);
        chk("rst_gid", 32'(gid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        rst = 1'b0;
        tick();

        // single byte, latency t+1 ready / t+2 dv
        setreq(1, 1'b1, 8'h41, 1'b1);
        tick();
        chk("single_ready", 32'(bus.o_req_ready), 32'b0010);
        chk("single_dv_early", 32'(bus.o_tx_dv), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        serve(1, 8'h41, 1'b0, 8'h00, 1'b0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // round-robin from reset: 0,1,2,3,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) setreq(k, 1'b1, 8'(8'h10 + k), 1'b1);
        for (int i = 0; i < 6; i++)
            serve(i % NR, 8'(8'h10 + i % NR), i < 4, 8'(8'h10 + i % NR), 1'b1);

        // lock: req2 packet AA,BB,CC beats waiting req3/req0
        setreq(0, 1'b1, 8'h50, 1'b1);
        setreq(3, 1'b1, 8'h53, 1'b1);
        setreq(2, 1'b1, 8'hAA, 1'b0);
        serve(2, 8'hAA, 1'b1, 8'hBB, 1'b0);
        serve(2, 8'hBB, 1'b1, 8'hCC, 1'b1);
        serve(2, 8'hCC, 1'b0, 8'h00, 1'b0);
        serve(3, 8'h53, 1'b0, 8'h00, 1'b0);
        serve(0, 8'h50, 1'b0, 8'h00, 1'b0);

        // busy transmitter holds off; lone requester equal to ptr wins full circle
        bus.i_tx_active = 1'b1;
        setreq(0, 1'b1, 8'h60, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("active_ready", 32'(bus.o_req_ready), 32'd0);
        end
        chk("active_dv", 32'(bus.o_tx_dv), 32'd0);
        bus.i_tx_active = 1'b0;
        tick();
        chk("active_release", 32'(bus.o_req_ready), 32'b0001);
        serve(0, 8'h60, 1'b0, 8'h00, 1'b0);

        // watchdog abort under lock
        setreq(1, 1'b1, 8'h71, 1'b0);
        setreq(2, 1'b1, 8'h72, 1'b1);
        serve(1, 8'h71, 1'b1, 8'h7A, 1'b0);
        tick();
        chk("tmo_lock_ready", 32'(bus.o_req_ready), 32'b0010);
        tick();
        setreq(1, 1'b0, 8'h00, 1'b0);
        chk("tmo_kick_dv", 32'(bus.o_tx_dv), 32'd1);
        chk("tmo_kick_byte", 32'(bus.o_tx_byte), 32'h7A);
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!tmo && n < 150);
            chk("tmo_delay", 32'(n), 32'd100);
        end
        chk("tmo_pulse", 32'(tmo), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick();
        chk("tmo_pulse_end", 32'(tmo), 32'd0);
        chk("tmo_next_grant", 32'(bus.o_req_ready), 32'b0100);
        serve(2, 8'h72, 1'b0, 8'h00, 1'b0);

        // reset in WAIT_DONE while locked, then a stray tx_done
        setreq(3, 1'b1, 8'h83, 1'b0);
        setreq(0, 1'b1, 8'h80, 1'b1);
        serve(3, 8'h83, 1'b1, 8'h84, 1'b0);
        tick();
        chk("rl_ready", 32'(bus.o_req_ready), 32'b1000);
        tick();
        setreq(3, 1'b0, 8'h00, 1'b0);
        chk("rl_dv", 32'(bus.o_tx_dv), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        setreq(0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        chk("rl_rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rl_rst_dv", 32'(bus.o_tx_dv), 32'd0);
        chk("rl_rst_byte", 32'(bus.o_tx_byte), 32'd0);
        chk("rl_rst_gid", 32'(gid), 32'd0);
        chk("rl_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("stray_dv", 32'(bus.o_tx_dv), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        tick();
        chk("stray_dv2", 32'(bus.o_tx_dv), 32'd0);
        chk("stray_ready", 32'(bus.o_req_ready), 32'd0);
        setreq(3, 1'b1, 8'h85, 1'b1);
        setreq(0, 1'b1, 8'h86, 1'b1);
        serve(0, 8'h86, 1'b0, 8'h00, 1'b0);
        serve(3, 8'h85, 1'b0, 8'h00, 1'b0);
        chk("final_hold_byte", 32'(bus.o_tx_byte), 32'h85);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_top transmitter among NUM_REQ byte producers, e.g. echo path, status reporter and debug dump. Uses round-robin arbitration with optional packet locking: a requester keeps the grant until it sends a byte flagged last. Drives the transmitter's i_tx_dv/i_tx_byte, sequences one byte at a time against o_tx_done, and runs a watchdog against a hung transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle cycles inserted after each tx_done before the next arbitration (0..255)
TIMEOUT_CYCLES, 65535, max cycles waiting for i_tx_done before abort (must exceed 11*CLKS_PER_BIT)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  NUM_REQ  requester k has a byte pending
i_req_byte  in  8*NUM_REQ  packed; requester k at [8k+7:8k]
i_req_last  in  NUM_REQ  byte is last of packet; releases lock
o_req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
o_tx_dv  out  1  one-cycle start pulse to transmitter
o_tx_byte  out  8  byte to transmitter, stable from o_tx_dv until tx_done
i_tx_active  in  1  transmitter busy
i_tx_done  in  1  transmitter frame-complete pulse
o_grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
o_busy  out  1  high in any state other than IDLE
o_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (i_rst high at posedge): state=IDLE; o_req_ready=0, o_tx_dv=0, o_tx_byte=0, o_grant_id=0, o_busy=0, o_timeout=0; lock cleared; rr pointer=NUM_REQ-1, so requester 0 wins first. Reset mid-frame does not abort a frame already inside uart_top; a late i_tx_done after reset is ignored.
- Requester rule: once valid is high, it stays high with byte/last stable until accepted. A violation is undefined.
- FSM, all outputs registered:
  IDLE: if i_tx_active=1, stay. Else if lock set: wait for i_req_valid[owner] only; others are ignored. Else if any valid: pick first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ. On a pick -> GRANT, o_grant_id=g.
  GRANT (1 cycle): o_req_ready[g]=1. Capture byte into o_tx_byte and last into last_r. ptr<=g. -> KICK.
  KICK (1 cycle): o_tx_dv=1. -> WAIT_DONE, watchdog cleared.
  WAIT_DONE: on i_tx_done -> GAP, or IDLE if GAP_CYCLES=0. Lock update on done: last_r=0 -> lock=1, owner=g; last_r=1 -> lock=0. If watchdog reaches TIMEOUT_CYCLES: o_timeout pulse, lock=0, -> IDLE.
  GAP: count GAP_CYCLES cycles -> IDLE.
- Latency: valid rises in cycle t with FSM in IDLE and tx idle -> o_req_ready at t+1, o_tx_dv at t+2. i_tx_done at cycle d -> IDLE at d+1+GAP_CYCLES. Earliest next o_req_ready is at d+2+GAP_CYCLES.
- i_tx_done outside WAIT_DONE is ignored. Simultaneous requests resolve purely by the rr pointer. A locked owner that drops valid stalls all others until it resumes or until reset (documented hazard).
- Pointer wrap: ptr=NUM_REQ-1 searches 0 next. The only valid being the pointer itself is still granted on its full-circle turn.
- o_tx_byte holds its value after a transfer until the next GRANT.

Test Plan:
- Single: req1 sends 0x41 last=1 after reset -> ready[1] at t+1, tx_dv at t+2, o_tx_byte=0x41; done -> IDLE, o_busy=0.
- Round-robin: all 4 valid continuously, last=1 -> grant order 0,1,2,3,0,1; o_req_ready always one-hot.
- Lock: req2 sends 0xAA last=0, 0xBB last=0, 0xCC last=1 while req0 and req3 are valid -> order 2,2,2,3,0; o_tx_byte sequence AA,BB,CC.
- Busy transmitter: i_tx_active=1 with req0 valid -> no ready/tx_dv until active drops; then ready at next cycle.
- Timeout: TIMEOUT_CYCLES=100, never assert i_tx_done -> o_timeout one-cycle pulse 100 cycles after KICK, lock cleared, next requester granted.
- Reset in WAIT_DONE under lock -> all outputs 0, lock cleared; a stray i_tx_done 3 cycles later causes no tx_dv; next grant goes to req0.
